// File: rtl/acc_cpu_pkg.sv
// Shared types for the multi-cycle accumulator CPU: opcodes, FSM states, instruction width.
// Pure declarations; no logic or latency of its own.
// No flow control here; handshakes live in acc_cpu_mc_if.
package acc_cpu_pkg;

    typedef enum logic [2:0] {
        OP_LDA = 3'b000,
        OP_STA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_JC  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_HALT
    } state_e;

    // Instruction word = 3-bit opcode on top of an ADDR_W-bit operand.
    function automatic int IW(input int addr_w);
        return 3 + addr_w;
    endfunction

endpackage

// File: rtl/acc_cpu_mc_if.sv
// Instruction and data memory req/ack buses of the accumulator CPU.
// Latency set by the attached memories; zero-wait ack allowed.
// Backpressure: a request holds address/data stable until its ack is sampled.
interface acc_cpu_mc_if
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    localparam int INSN_W = IW(ADDR_W);

    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INSN_W-1:0] imem_rdata_i;
    logic              imem_ack_i;

    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              dmem_ack_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rdata_i, imem_ack_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rdata_i, imem_ack_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ack_i
    );

endinterface

// File: rtl/acc_alu_w.sv
// Accumulator ALU for LDA/ADD/SUB/AND with zero and carry/borrow results.
// Latency: combinational.
// No flow control; the caller decides which results to commit.
module acc_alu_w
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  op_e               op,
    output logic [DATA_W-1:0] r,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum  = {1'b0, x} + {1'b0, y};
        diff = {1'b0, x} - {1'b0, y};
        r    = y;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                r = sum[DATA_W-1:0];
                c = sum[DATA_W];
            end
            // Top bit of the widened difference is set exactly when x < y.
            OP_SUB: begin
                r = diff[DATA_W-1:0];
                c = diff[DATA_W];
            end
            OP_AND:  r = x & y;
            default: r = y;
        endcase
        z = (r == '0);
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: fetch/decode/execute FSM, halt on jump-to-self, retired counter.
// Latency: 3 cycles per memory-operand instruction, 2 per branch, +1 per memory wait state.
// Backpressure: each state stalls with req held until the matching ack; acks without req are ignored.
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    acc_cpu_mc_if.master           bus,
    output logic [DATA_W-1:0]      acc_o,
    output logic [ADDR_W-1:0]      pc_o,
    output logic [IW(ADDR_W)-1:0]  ir_o,
    output logic                   flag_z_o,
    output logic                   flag_c_o,
    output logic                   halt_o,
    output logic [CNT_W-1:0]       retired_o
);

    localparam int INSN_W = IW(ADDR_W);

    state_e            state;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] ir;
    logic              flag_z;
    logic              flag_c;
    logic              halt;
    logic [CNT_W-1:0]  retired;
    logic              imem_req;
    logic              dmem_req;
    logic              dmem_we;

    op_e               op;
    logic [ADDR_W-1:0] opnd;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  retired_nxt;
    logic              is_branch;
    logic              taken;
    logic [DATA_W-1:0] alu_r;
    logic              alu_z;
    logic              alu_c;

    assign op          = op_e'(ir[INSN_W-1:ADDR_W]);
    assign opnd        = ir[ADDR_W-1:0];
    assign pc_inc      = pc + 1'b1;
    assign retired_nxt = (&retired) ? retired : retired + 1'b1;
    assign is_branch   = (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    assign taken       = (op == OP_JMP) || (op == OP_JZ && flag_z) || (op == OP_JC && flag_c);

    acc_alu_w #(.DATA_W(DATA_W)) u_alu (
        .x  (acc),
        .y  (bus.dmem_rdata_i),
        .op (op),
        .r  (alu_r),
        .z  (alu_z),
        .c  (alu_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_FETCH;
            acc      <= '0;
            pc       <= '0;
            ir       <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            halt     <= 1'b0;
            retired  <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end else begin
            case (state)
                // First cycle out of reset raises the request; later fetches arrive with it already set.
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (bus.imem_ack_i) begin
                        ir       <= bus.imem_rdata_i;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_branch) begin
                        retired <= retired_nxt;
                        if (op == OP_JMP && opnd == pc) begin
                            halt  <= 1'b1;
                            state <= S_HALT;
                        end else begin
                            pc       <= taken ? opnd : pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (op == OP_STA);
                        state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack_i) begin
                        if (op != OP_STA) begin
                            acc    <= alu_r;
                            flag_z <= alu_z;
                            if (op == OP_ADD || op == OP_SUB) flag_c <= alu_c;
                        end
                        retired  <= retired_nxt;
                        pc       <= pc_inc;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    assign bus.imem_req_o   = imem_req;
    assign bus.imem_addr_o  = pc;
    assign bus.dmem_req_o   = dmem_req;
    assign bus.dmem_we_o    = dmem_we;
    assign bus.dmem_addr_o  = opnd;
    assign bus.dmem_wdata_o = acc;

    assign acc_o     = acc;
    assign pc_o      = pc;
    assign ir_o      = ir;
    assign flag_z_o  = flag_z;
    assign flag_c_o  = flag_c;
    assign halt_o    = halt;
    assign retired_o = retired;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: directed programs plus random wait-state programs against an ISA-level model.
module tb_acc_cpu_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] acc;
    logic [4:0] pc;
    logic [7:0] ir;
    logic       fz, fc, halt;
    logic [3:0] retired;

    int checks = 0;
    int errors = 0;

    logic [7:0] imem [32];
    logic [7:0] dmem [32];
    logic [7:0] m_dmem [32];

    bit rnd = 1'b0;
    bit noisy = 1'b0;
    int d_fix = 0;

    int m_acc, m_z, m_c, m_pc, m_ret, m_halt;

    acc_cpu_mc_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    acc_cpu_mc #(.DATA_W(8), .ADDR_W(5), .CNT_W(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .acc_o     (acc),
        .pc_o      (pc),
        .ir_o      (ir),
        .flag_z_o  (fz),
        .flag_c_o  (fc),
        .halt_o    (halt),
        .retired_o (retired)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction memory: optional random wait states and spurious acks while idle.
    bit         i_busy = 1'b0;
    int         i_left = 0;
    logic [4:0] i_addr_l;
    always @(negedge clk) begin
        if (!rst_n || !bus.imem_req_o) begin
            i_busy = 1'b0;
            bus.imem_ack_i = noisy && ($urandom_range(0, 3) == 0);
            bus.imem_rdata_i = 8'($urandom);
        end else begin
            if (i_busy) check("imem_addr_stable", 32'(bus.imem_addr_o), 32'(i_addr_l));
            else begin
                i_busy = 1'b1;
                i_addr_l = bus.imem_addr_o;
                i_left = rnd ? int'($urandom_range(0, 4)) : 0;
            end
            if (i_left == 0) begin
                bus.imem_ack_i = 1'b1;
                bus.imem_rdata_i = imem[bus.imem_addr_o];
                i_busy = 1'b0;
            end else begin
                bus.imem_ack_i = 1'b0;
                bus.imem_rdata_i = 8'($urandom);
                i_left--;
            end
        end
    end

    bit         d_busy = 1'b0;
    int         d_left = 0;
    logic [4:0] d_addr_l;
    logic [7:0] d_wdata_l;
    logic       d_we_l;
    always @(negedge clk) begin
        if (!rst_n || !bus.dmem_req_o) begin
            d_busy = 1'b0;
            bus.dmem_ack_i = noisy && ($urandom_range(0, 3) == 0);
            bus.dmem_rdata_i = 8'($urandom);
        end else begin
            if (d_busy) begin
                check("dmem_addr_stable", 32'(bus.dmem_addr_o), 32'(d_addr_l));
                check("dmem_we_stable", 32'(bus.dmem_we_o), 32'(d_we_l));
                if (d_we_l) check("dmem_wdata_stable", 32'(bus.dmem_wdata_o), 32'(d_wdata_l));
            end else begin
                d_busy = 1'b1;
                d_addr_l = bus.dmem_addr_o;
                d_we_l = bus.dmem_we_o;
                d_wdata_l = bus.dmem_wdata_o;
                d_left = rnd ? int'($urandom_range(0, 4)) : d_fix;
            end
            if (d_left == 0) begin
                bus.dmem_ack_i = 1'b1;
                if (bus.dmem_we_o) dmem[bus.dmem_addr_o] = bus.dmem_wdata_o;
                bus.dmem_rdata_i = dmem[bus.dmem_addr_o];
                d_busy = 1'b0;
            end else begin
                bus.dmem_ack_i = 1'b0;
                bus.dmem_rdata_i = 8'($urandom);
                d_left--;
            end
        end
    end

    // Instruction-set interpreter: runs the program in imem on m_dmem until jump-to-self.
    task automatic ref_run();
        int o, t, a, d, s, steps;
        m_acc = 0; m_z = 0; m_c = 0; m_pc = 0; m_ret = 0; m_halt = 0; steps = 0;
        while (m_halt == 0 && steps < 500) begin
            o = int'(imem[m_pc] >> 5);
            t = int'(imem[m_pc] & 8'h1F);
            a = m_acc;
            d = int'(m_dmem[t]);
            steps++;
            m_ret = (m_ret == 15) ? 15 : m_ret + 1;
            case (o)
                0: m_acc = d;
                1: m_dmem[t] = 8'(m_acc);
                2: begin s = a + d; m_acc = s % 256; m_c = (s > 255) ? 1 : 0; end
                3: begin m_c = (a < d) ? 1 : 0; m_acc = (a - d + 256) % 256; end
                4: m_acc = a & d;
                default: ;
            endcase
            if (o == 0 || o == 2 || o == 3 || o == 4) m_z = (m_acc == 0) ? 1 : 0;
            if (o <= 4) m_pc = (m_pc + 1) % 32;
            else if (o == 5 && t == m_pc) m_halt = 1;
            else if (o == 5 || (o == 6 && m_z == 1) || (o == 7 && m_c == 1)) m_pc = t;
            else m_pc = (m_pc + 1) % 32;
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
    endtask

    // Reset, check reset state, release on a falling edge, return 1ns after the first rising edge.
    task automatic start();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", 32'(acc), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_flags", {30'd0, fz, fc}, 0);
        check("rst_halt", 32'(halt), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_reqs", {29'd0, bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_fetch_req", 32'(bus.imem_req_o), 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int req_seen, mism;
        bus.imem_ack_i = 1'b0;
        bus.imem_rdata_i = '0;
        bus.dmem_ack_i = 1'b0;
        bus.dmem_rdata_i = '0;

        // Zero-wait LDA/ADD/STA.
        clear_mems();
        imem[0] = 8'h10; imem[1] = 8'h51; imem[2] = 8'h32; imem[3] = 8'hA3;
        dmem[16] = 8'h05; dmem[17] = 8'hFC;
        start();
        cycles(9);
        check("prog_retired", 32'(retired), 3);
        check("prog_acc", 32'(acc), 32'h01);
        check("prog_c", 32'(fc), 1);
        check("prog_z", 32'(fz), 0);
        check("prog_store", 32'(dmem[18]), 32'h01);
        check("prog_pc", 32'(pc), 3);

        // SUB with borrow, then AND to zero.
        clear_mems();
        imem[0] = 8'h10; imem[1] = 8'h71; imem[2] = 8'h92; imem[3] = 8'hA3;
        dmem[16] = 8'h03; dmem[17] = 8'h04; dmem[18] = 8'h00;
        start();
        cycles(6);
        check("sub_acc", 32'(acc), 32'hFF);
        check("sub_flags", {30'd0, fz, fc}, 32'b01);
        cycles(3);
        check("and_acc", 32'(acc), 0);
        check("and_flags", {30'd0, fz, fc}, 32'b11);

        // Branches: JZ not taken, JC taken, JMP chain into halt at the top address.
        clear_mems();
        imem[0] = 8'hC5; imem[1] = 8'h10; imem[2] = 8'h51; imem[3] = 8'hE7;
        imem[7] = 8'hBF; imem[31] = 8'hBF;
        dmem[16] = 8'hFF; dmem[17] = 8'h01;
        start();
        cycles(2);
        check("jz_nt_pc", 32'(pc), 1);
        check("jz_nt_retired", 32'(retired), 1);
        cycles(8);
        check("jc_pc", 32'(pc), 7);
        check("jc_retired", 32'(retired), 4);
        check("jc_state", {22'd0, acc, fz, fc}, 32'b11);
        cycles(2);
        check("jmp_pc", 32'(pc), 31);
        check("jmp_halt_early", 32'(halt), 0);
        cycles(2);
        check("halt", 32'(halt), 1);
        check("halt_pc", 32'(pc), 31);
        check("halt_retired", 32'(retired), 6);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (bus.imem_req_o || bus.dmem_req_o) req_seen++;
        end
        check("halt_no_req", 32'(req_seen), 0);
        check("halt_retired_frozen", 32'(retired), 6);

        // PC wrap from the top address, and the counter saturating in the resulting loop.
        clear_mems();
        imem[0] = 8'hBF; imem[31] = 8'h10;
        dmem[16] = 8'h3C;
        start();
        cycles(2);
        check("wrap_pre_pc", 32'(pc), 31);
        cycles(3);
        check("wrap_pc", 32'(pc), 0);
        check("wrap_fetch", {26'd0, bus.imem_req_o, bus.imem_addr_o}, 32'h20);
        check("wrap_acc", 32'(acc), 32'h3C);
        cycles(30);
        check("cnt_pre_sat", 32'(retired), 14);
        cycles(5);
        check("cnt_sat", 32'(retired), 15);
        cycles(20);
        check("cnt_sat_hold", 32'(retired), 15);

        // Reset while a data read is pending.
        clear_mems();
        imem[0] = 8'h10; imem[1] = 8'h11;
        dmem[16] = 8'hAA; dmem[17] = 8'h55;
        d_fix = 3;
        start();
        for (int i = 0; i < 60; i++) begin
            if (bus.dmem_req_o && pc == 5'd1) break;
            cycles(1);
        end
        check("abort_req_seen", 32'(bus.dmem_req_o), 1);
        check("abort_acc_before", 32'(acc), 32'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_dmem_req", 32'(bus.dmem_req_o), 0);
        check("abort_pc", 32'(pc), 0);
        check("abort_acc", 32'(acc), 0);
        check("abort_retired", 32'(retired), 0);
        d_fix = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        check("abort_refetch", {26'd0, bus.imem_req_o, bus.imem_addr_o}, 32'h20);

        // Random forward-only programs under random wait states and stray acks.
        rnd = 1'b1;
        noisy = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 32; a++) begin
                logic [2:0] o;
                o = 3'($urandom_range(0, 7));
                if (a < 20 && o >= 3'd5) imem[a] = {o, 5'($urandom_range(a + 1, 20))};
                else imem[a] = {o, 5'($urandom_range(0, 31))};
                dmem[a] = 8'($urandom);
                m_dmem[a] = dmem[a];
            end
            imem[20] = {3'd5, 5'd20};
            ref_run();
            start();
            for (int i = 0; i < 3000 && !halt; i++) cycles(1);
            check("rand_halt", 32'(halt), 1);
            check("rand_acc", 32'(acc), 32'(m_acc));
            check("rand_z", 32'(fz), 32'(m_z));
            check("rand_c", 32'(fc), 32'(m_c));
            check("rand_pc", 32'(pc), 32'(m_pc));
            check("rand_retired", 32'(retired), 32'(m_ret));
            mism = 0;
            for (int a = 0; a < 32; a++) if (dmem[a] !== m_dmem[a]) mism++;
            check("rand_dmem", 32'(mism), 0);
        end
        rnd = 1'b0;
        noisy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
